// File: rtl/npu_host_issuer_pkg.sv
// Shared widths and issuer FSM encoding for the NPU host issuer.
package npu_host_issuer_pkg;

    localparam int unsigned BIT_INSTR = 32;
    localparam int unsigned BIT_PSUM  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DRAIN = 3'd4
    } issuer_state_e;

endpackage

// File: rtl/npu_host_issuer_sync_fifo.sv
// Synchronous FIFO with registered read port, read-valid strobe and occupancy count.
// A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module npu_host_issuer_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic [CW-1:0]    count_o
);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty_c;
    logic full_c;
    logic rd_fire_c;
    logic wr_fire_c;

    // Full/empty from pointers: the extra MSB separates a wrapped-full queue from an empty one.
    always_comb begin
        empty_c   = (wr_ptr_q == rd_ptr_q);
        full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_fire_c = rd_en_i && !empty_c;
        wr_fire_c = wr_en_i && (!full_c || rd_fire_c);
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_fire_c) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (rd_fire_c) begin
                rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
            rd_valid_q <= rd_fire_c;
            count_q    <= count_q + CW'(wr_fire_c) - CW'(rd_fire_c);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;

endmodule

// File: rtl/npu_host_issuer.sv
// Host-side issuer: queues host instructions, issues them to the NPU as a held word
// plus one-cycle pulse under stall control, and buffers NPU writebacks for the host.
module npu_host_issuer
    import npu_host_issuer_pkg::*;
#(
    parameter int unsigned IQ_DEPTH  = 16,
    parameter int unsigned RB_DEPTH  = 64,
    parameter int unsigned ISSUE_GAP = 2,
    localparam int unsigned IQ_CW    = $clog2(IQ_DEPTH) + 1,
    localparam int unsigned RB_CW    = $clog2(RB_DEPTH) + 1,
    localparam int unsigned GAP_W    = $clog2(ISSUE_GAP + 2)
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic                 i_host_instr_valid,
    input  logic [BIT_INSTR-1:0] i_host_instr_data,
    output logic                 o_host_instr_ready,
    input  logic                 i_start,
    output logic [BIT_INSTR-1:0] o_Instr_Out,
    output logic                 o_instr_pulse,
    input  logic                 i_instr_stall,
    input  logic                 i_Valid_WB,
    input  logic [BIT_PSUM-1:0]  i_Data_WB,
    input  logic                 i_Flag_Finish,
    input  logic                 i_rd_en,
    output logic [BIT_PSUM-1:0]  o_rd_data,
    output logic                 o_rd_valid,
    output logic [RB_CW-1:0]     o_rb_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow
);

    issuer_state_e    state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             iq_pop_c;
    logic [IQ_CW-1:0] iq_count;
    logic             iq_full_c;
    logic             iq_empty_c;
    logic             rb_full_c;

    always_comb begin
        iq_full_c  = (iq_count == IQ_CW'(IQ_DEPTH));
        iq_empty_c = (iq_count == '0);
        rb_full_c  = (o_rb_count == RB_CW'(RB_DEPTH));
    end

    // Instruction queue: its registered read port is the held NPU instruction word,
    // and its read-valid strobe is the issue pulse (pop is taken on the ARM decision).
    npu_host_issuer_sync_fifo #(
        .WIDTH (BIT_INSTR),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk        (CLK),
        .rst_n      (RSTb),
        .wr_en_i    (i_host_instr_valid && !iq_full_c),
        .wr_data_i  (i_host_instr_data),
        .rd_en_i    (iq_pop_c),
        .rd_data_o  (o_Instr_Out),
        .rd_valid_o (o_instr_pulse),
        .count_o    (iq_count)
    );

    // Result buffer for NPU writebacks, drained by the host.
    npu_host_issuer_sync_fifo #(
        .WIDTH (BIT_PSUM),
        .DEPTH (RB_DEPTH)
    ) u_rb (
        .clk        (CLK),
        .rst_n      (RSTb),
        .wr_en_i    (i_Valid_WB),
        .wr_data_i  (i_Data_WB),
        .rd_en_i    (i_rd_en),
        .rd_data_o  (o_rd_data),
        .rd_valid_o (o_rd_valid),
        .count_o    (o_rb_count)
    );

    // Issue FSM next-state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        done_d   = done_q;
        iq_pop_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ARM;
                    done_d  = 1'b0;
                end
            end
            ST_ARM: begin
                if (iq_empty_c) begin
                    state_d = ST_DRAIN;
                end else if (!i_instr_stall) begin
                    state_d  = ST_ISSUE;
                    iq_pop_c = 1'b1;
                end
            end
            ST_ISSUE: begin
                gap_d   = GAP_W'(ISSUE_GAP);
                state_d = (ISSUE_GAP == 0) ? ST_ARM : ST_GAP;
            end
            ST_GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_ARM;
                end
            end
            ST_DRAIN: begin
                if (i_Flag_Finish) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sticky overflow: a writeback into a full buffer with no simultaneous pop is lost.
    always_comb begin
        ovf_d = ovf_q || (i_Valid_WB && rb_full_c && !i_rd_en);
    end

    // FSM state and status registers.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_host_instr_ready = !iq_full_c;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_npu_host_issuer.sv
// Directed and randomized bench for npu_host_issuer with queue-based reference models.
module tb_npu_host_issuer;
    import npu_host_issuer_pkg::*;

    localparam int unsigned IQ_DEPTH  = 16;
    localparam int unsigned RB_DEPTH  = 64;
    localparam int unsigned ISSUE_GAP = 2;
    localparam int unsigned RB_CW     = $clog2(RB_DEPTH) + 1;

    logic                 CLK;
    logic                 RSTb;
    logic                 i_host_instr_valid;
    logic [BIT_INSTR-1:0] i_host_instr_data;
    logic                 o_host_instr_ready;
    logic                 i_start;
    logic [BIT_INSTR-1:0] o_Instr_Out;
    logic                 o_instr_pulse;
    logic                 i_instr_stall;
    logic                 i_Valid_WB;
    logic [BIT_PSUM-1:0]  i_Data_WB;
    logic                 i_Flag_Finish;
    logic                 i_rd_en;
    logic [BIT_PSUM-1:0]  o_rd_data;
    logic                 o_rd_valid;
    logic [RB_CW-1:0]     o_rb_count;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_overflow;

    npu_host_issuer #(
        .IQ_DEPTH  (IQ_DEPTH),
        .RB_DEPTH  (RB_DEPTH),
        .ISSUE_GAP (ISSUE_GAP)
    ) dut (
        .CLK                (CLK),
        .RSTb               (RSTb),
        .i_host_instr_valid (i_host_instr_valid),
        .i_host_instr_data  (i_host_instr_data),
        .o_host_instr_ready (o_host_instr_ready),
        .i_start            (i_start),
        .o_Instr_Out        (o_Instr_Out),
        .o_instr_pulse      (o_instr_pulse),
        .i_instr_stall      (i_instr_stall),
        .i_Valid_WB         (i_Valid_WB),
        .i_Data_WB          (i_Data_WB),
        .i_Flag_Finish      (i_Flag_Finish),
        .i_rd_en            (i_rd_en),
        .o_rd_data          (o_rd_data),
        .o_rd_valid         (o_rd_valid),
        .o_rb_count         (o_rb_count),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_overflow         (o_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and stall as seen by the DUT at each rising edge.
    int   cyc = 0;
    logic stall_at_edge = 1'b0;
    always @(posedge CLK) begin
        cyc           <= cyc + 1;
        stall_at_edge <= i_instr_stall;
    end

    // Pulse recorder plus issue-protocol rules checked every cycle.
    typedef struct {
        int          c;
        logic [31:0] d;
    } pulse_t;
    pulse_t      obs[$];
    bit          mon_en     = 1'b0;
    logic [31:0] prev_instr = '0;
    logic        prev_pulse = 1'b0;
    int          last_pulse = -100;

    always @(negedge CLK) begin
        if (o_instr_pulse === 1'b1) obs.push_back('{cyc, o_Instr_Out});
        if (mon_en) begin
            if (o_instr_pulse === 1'b1) begin
                chk("pulse_after_stall", 64'(stall_at_edge), 64'(0));
                chk("pulse_width", 64'(prev_pulse), 64'(0));
                chk("pulse_spacing", 64'(cyc - last_pulse >= int'(ISSUE_GAP) + 2), 64'(1));
            end else begin
                chk("instr_hold", 64'(o_Instr_Out), 64'(prev_instr));
            end
        end
        if (o_instr_pulse === 1'b1) last_pulse = cyc;
        prev_instr = o_Instr_Out;
        prev_pulse = o_instr_pulse;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic zero_inputs();
        i_host_instr_valid = 1'b0;
        i_host_instr_data  = '0;
        i_start            = 1'b0;
        i_instr_stall      = 1'b0;
        i_Valid_WB         = 1'b0;
        i_Data_WB          = '0;
        i_Flag_Finish      = 1'b0;
        i_rd_en            = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        zero_inputs();
        RSTb = 1'b0;
        repeat (3) tick();
        RSTb = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        i_host_instr_valid = 1'b1;
        i_host_instr_data  = d;
        tick();
        i_host_instr_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(o_done), 64'(1));
        i_Flag_Finish = 1'b0;
    endtask

    int          s;
    int          base;
    logic [31:0] exp_instr[$];
    logic [31:0] rbq[$];
    bit          exp_ovf;
    bit          rd_pend;
    logic [31:0] rd_exp;
    logic [31:0] d32;
    int          n;

    initial begin
        RSTb = 1'b1;
        zero_inputs();
        tick();
        do_reset();

        // Reset values
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_ovf", 64'(o_overflow), 64'(0));
        chk("rst_instr", 64'(o_Instr_Out), 64'(0));
        chk("rst_pulse", 64'(o_instr_pulse), 64'(0));
        chk("rst_rb_count", 64'(o_rb_count), 64'(0));
        chk("rst_rd_valid", 64'(o_rd_valid), 64'(0));
        chk("rst_ready", 64'(o_host_instr_ready), 64'(1));

        // Basic issue: three instructions, pulses at +2, +6, +10, finish at +15
        push(32'h11); push(32'h22); push(32'h33);
        base = obs.size();
        i_start = 1'b1; s = cyc;
        tick();
        i_start = 1'b0;
        wait_cyc(s + 14);
        chk("basic_busy_drain", 64'(o_busy), 64'(1));
        chk("basic_done_early", 64'(o_done), 64'(0));
        i_Flag_Finish = 1'b1;
        tick();
        i_Flag_Finish = 1'b0;
        chk("basic_done", 64'(o_done), 64'(1));
        chk("basic_busy_end", 64'(o_busy), 64'(0));
        chk("basic_npulses", 64'(obs.size() - base), 64'(3));
        for (int k = 0; k < 3 && base + k < obs.size(); k++) begin
            chk("basic_pulse_cyc", 64'(obs[base+k].c), 64'(s + 2 + 4*k));
            chk("basic_pulse_data", 64'(obs[base+k].d), 64'(32'h11 * (k + 1)));
        end

        // Stall hold: stall high until mid cycle s+8, pulse one cycle later
        push(32'h5A);
        base = obs.size();
        i_instr_stall = 1'b1; i_start = 1'b1; s = cyc;
        tick();
        i_start = 1'b0;
        wait_cyc(s + 8);
        chk("stall_no_pulse", 64'(obs.size() - base), 64'(0));
        chk("stall_done_cleared", 64'(o_done), 64'(0));
        i_instr_stall = 1'b0;
        i_Flag_Finish = 1'b1;
        wait_done("stall_done");
        chk("stall_npulses", 64'(obs.size() - base), 64'(1));
        if (obs.size() > base) begin
            chk("stall_pulse_cyc", 64'(obs[base].c), 64'(s + 9));
            chk("stall_pulse_data", 64'(obs[base].d), 64'(32'h5A));
        end
        chk("stall_instr_held", 64'(o_Instr_Out), 64'(32'h5A));

        // Queue full: 17 pushes while idle, only 16 accepted
        for (int i = 0; i < 17; i++) begin
            chk("qfull_ready", 64'(o_host_instr_ready), 64'(i < 16));
            push(32'h1000 + 32'(i));
        end
        chk("qfull_ready_end", 64'(o_host_instr_ready), 64'(0));
        base = obs.size();
        i_start = 1'b1; i_Flag_Finish = 1'b1; s = cyc;
        tick();
        i_start = 1'b0;
        wait_done("qfull_done");
        chk("qfull_npulses", 64'(obs.size() - base), 64'(16));
        for (int k = 0; k < 16 && base + k < obs.size(); k++) begin
            chk("qfull_pulse_cyc", 64'(obs[base+k].c), 64'(s + 2 + 4*k));
            chk("qfull_pulse_data", 64'(obs[base+k].d), 64'(32'h1000 + 32'(k)));
        end
        chk("qfull_ready_after", 64'(o_host_instr_ready), 64'(1));

        // Result buffer fill: 66 words into 64 slots, then drain in order
        do_reset();
        for (int i = 0; i < 66; i++) begin
            i_Valid_WB = 1'b1; i_Data_WB = 32'(i);
            tick();
        end
        i_Valid_WB = 1'b0;
        chk("fill_count", 64'(o_rb_count), 64'(64));
        chk("fill_ovf", 64'(o_overflow), 64'(1));
        i_rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("fill_rd_valid", 64'(o_rd_valid), 64'(1));
            chk("fill_rd_data", 64'(o_rd_data), 64'(i));
        end
        chk("fill_count_empty", 64'(o_rb_count), 64'(0));
        tick();
        i_rd_en = 1'b0;
        chk("empty_rd_valid", 64'(o_rd_valid), 64'(0));
        chk("empty_count", 64'(o_rb_count), 64'(0));

        // Simultaneous write and read on a full buffer
        do_reset();
        for (int i = 0; i < 64; i++) begin
            i_Valid_WB = 1'b1; i_Data_WB = 32'h100 + 32'(i);
            tick();
        end
        chk("simul_count_full", 64'(o_rb_count), 64'(64));
        chk("simul_ovf_before", 64'(o_overflow), 64'(0));
        i_Valid_WB = 1'b1; i_Data_WB = 32'hABC; i_rd_en = 1'b1;
        tick();
        i_Valid_WB = 1'b0;
        chk("simul_count", 64'(o_rb_count), 64'(64));
        chk("simul_ovf", 64'(o_overflow), 64'(0));
        chk("simul_rd_valid", 64'(o_rd_valid), 64'(1));
        chk("simul_rd_data", 64'(o_rd_data), 64'(32'h100));
        for (int k = 0; k < 64; k++) begin
            tick();
            chk("simul_drain", 64'(o_rd_data), 64'((k < 63) ? (32'h101 + 32'(k)) : 32'hABC));
        end
        i_rd_en = 1'b0;

        // Reset during GAP
        do_reset();
        push(32'h77); push(32'h88);
        base = obs.size();
        i_start = 1'b1; s = cyc;
        tick();
        i_start = 1'b0;
        wait_cyc(s + 3);
        chk("rgap_one_pulse", 64'(obs.size() - base), 64'(1));
        mon_en = 1'b0;
        #2 RSTb = 1'b0;
        #1;
        chk("rgap_pulse", 64'(o_instr_pulse), 64'(0));
        chk("rgap_instr", 64'(o_Instr_Out), 64'(0));
        chk("rgap_busy", 64'(o_busy), 64'(0));
        chk("rgap_done", 64'(o_done), 64'(0));
        chk("rgap_ovf", 64'(o_overflow), 64'(0));
        chk("rgap_rb_count", 64'(o_rb_count), 64'(0));
        chk("rgap_rd_valid", 64'(o_rd_valid), 64'(0));
        tick(); tick();
        RSTb = 1'b1;
        tick();
        mon_en = 1'b1;
        base = obs.size();
        repeat (20) tick();
        chk("rgap_quiet", 64'(obs.size() - base), 64'(0));
        chk("rgap_idle", 64'(o_busy), 64'(0));
        push(32'h99);
        i_start = 1'b1; i_Flag_Finish = 1'b1; s = cyc;
        tick();
        i_start = 1'b0;
        wait_done("rgap_done_after");
        chk("rgap_npulses", 64'(obs.size() - base), 64'(1));
        if (obs.size() > base) begin
            chk("rgap_new_cyc", 64'(obs[base].c), 64'(s + 2));
            chk("rgap_new_data", 64'(obs[base].d), 64'(32'h99));
        end

        // Randomized traffic against queue models
        do_reset();
        exp_instr.delete(); rbq.delete();
        exp_ovf = 1'b0; rd_pend = 1'b0; rd_exp = '0;
        base = obs.size();
        for (int it = 0; it < 800; it++) begin
            chk("rand_rb_count", 64'(o_rb_count), 64'(rbq.size()));
            chk("rand_ovf", 64'(o_overflow), 64'(exp_ovf));
            chk("rand_rd_valid", 64'(o_rd_valid), 64'(rd_pend));
            if (rd_pend) chk("rand_rd_data", 64'(o_rd_data), 64'(rd_exp));

            i_host_instr_valid = ($urandom_range(0, 2) == 0);
            i_host_instr_data  = $urandom;
            if (i_host_instr_valid && o_host_instr_ready) exp_instr.push_back(i_host_instr_data);
            i_start       = ($urandom_range(0, 9) == 0);
            i_instr_stall = ($urandom_range(0, 3) == 0);
            i_Flag_Finish = ($urandom_range(0, 4) == 0);
            case (it / 200)
                0:       begin i_Valid_WB = ($urandom_range(0, 9) < 8); i_rd_en = ($urandom_range(0, 9) < 2); end
                1:       begin i_Valid_WB = ($urandom_range(0, 1) == 0); i_rd_en = ($urandom_range(0, 1) == 0); end
                2:       begin i_Valid_WB = ($urandom_range(0, 9) < 3); i_rd_en = ($urandom_range(0, 9) < 7); end
                default: begin i_Valid_WB = ($urandom_range(0, 9) < 7); i_rd_en = ($urandom_range(0, 9) < 7); end
            endcase
            i_Data_WB = $urandom;

            rd_pend = i_rd_en && (rbq.size() > 0);
            if (rd_pend) rd_exp = rbq.pop_front();
            if (i_Valid_WB) begin
                if (rbq.size() < RB_DEPTH) rbq.push_back(i_Data_WB);
                else exp_ovf = 1'b1;
            end
            tick();
        end
        chk("rand_rb_count_end", 64'(o_rb_count), 64'(rbq.size()));
        chk("rand_ovf_end", 64'(o_overflow), 64'(exp_ovf));
        chk("rand_rd_valid_end", 64'(o_rd_valid), 64'(rd_pend));
        if (rd_pend) chk("rand_rd_data_end", 64'(o_rd_data), 64'(rd_exp));

        // Flush whatever is still queued and compare the full issue order
        zero_inputs();
        i_Flag_Finish = 1'b1;
        n = 0;
        while (((obs.size() - base) < exp_instr.size() || o_busy) && n < 3000) begin
            i_start = !o_busy && ((obs.size() - base) < exp_instr.size());
            tick();
            n++;
        end
        i_start = 1'b0;
        i_Flag_Finish = 1'b0;
        chk("rand_flush_idle", 64'(o_busy), 64'(0));
        chk("rand_npulses", 64'(obs.size() - base), 64'(exp_instr.size()));
        for (int k = 0; k < exp_instr.size() && base + k < obs.size(); k++) begin
            d32 = exp_instr[k];
            chk("rand_issue_order", 64'(obs[base+k].d), 64'(d32));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
